// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator with pixel-enable aligned sync/blank delay line
module vga_timing_gen #(
  parameter int HACTIVE   = 640,
  parameter int HFP       = 16,
  parameter int HSYN      = 96,
  parameter int HBP       = 48,
  parameter int VACTIVE   = 480,
  parameter int VFP       = 11,
  parameter int VSYN      = 2,
  parameter int VBP       = 32,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE      = 2,
  parameter int CW        = 10,
  parameter int FCW       = 8
) (
  input  logic           vgaclk,
  input  logic           reset_b,
  input  logic           pix_en,
  output logic           hsync,
  output logic           vsync,
  output logic           sync_b,
  output logic           blank_b,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);
  localparam int HTOTAL = HACTIVE + HFP + HSYN + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYN + VBP;
  if (HTOTAL > 2 ** CW) begin : g_htotal_chk
    $error("HTOTAL does not fit in CW-bit counter");
  end
  if (VTOTAL > 2 ** CW) begin : g_vtotal_chk
    $error("VTOTAL does not fit in CW-bit counter");
  end
  logic [CW-1:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           hend, vend;
  logic [2:0]     raw, dly_out;
  // next raster position and raw (undelayed) sync/active flags
  always_comb begin
    hend = hcnt_q == CW'(HTOTAL - 1);
    vend = vcnt_q == CW'(VTOTAL - 1);
    hcnt_d = !pix_en ? hcnt_q : hend ? '0 : hcnt_q + 1'b1;
    vcnt_d = !(pix_en && hend) ? vcnt_q : vend ? '0 : vcnt_q + 1'b1;
    frame_cnt_d = (pix_en && hend && vend) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    raw[2] = int'(hcnt_q) >= HACTIVE + HFP && int'(hcnt_q) < HACTIVE + HFP + HSYN;
    raw[1] = int'(vcnt_q) >= VACTIVE + VFP && int'(vcnt_q) < VACTIVE + VFP + VSYN;
    raw[0] = int'(hcnt_q) < HACTIVE && int'(vcnt_q) < VACTIVE;
  end
  // raster counters and frame counter
  always_ff @(posedge vgaclk or negedge reset_b) begin
    if (!reset_b) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  if (PIPE == 0) begin : g_nopipe
    assign dly_out = raw;
  end else begin : g_pipe
    logic [PIPE-1:0][2:0] dly_q, dly_d;
    // shift raw flags one stage per enabled pixel
    always_comb begin
      dly_d = dly_q;
      if (pix_en) begin
        dly_d[0] = raw;
        for (int i = 1; i < PIPE; i++) dly_d[i] = dly_q[i-1];
      end
    end
    // delay stages clear to "not in sync, not visible" so the first pixels after reset stay blanked
    always_ff @(posedge vgaclk or negedge reset_b) begin
      if (!reset_b) dly_q <= '0;
      else dly_q <= dly_d;
    end
    assign dly_out = dly_q[PIPE-1];
  end
  assign hsync       = dly_out[2] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = dly_out[1] ? VSYNC_POL : ~VSYNC_POL;
  assign blank_b     = dly_out[0];
  assign sync_b      = 1'b0;
  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign line_start  = pix_en && hcnt_q == '0;
  assign frame_start = pix_en && hcnt_q == '0 && vcnt_q == '0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-enable bench checking three configurations against an arithmetic raster model
module tb_vga_timing_gen;
  logic vgaclk = 1'b0, reset_b = 1'b1, pix_en = 1'b0;
  always #5 vgaclk = ~vgaclk;

  logic hs0, vs0, sb0, bl0, ls0, fs0;
  logic [9:0] x0, y0;
  logic [7:0] fc0;
  logic hs1, vs1, sb1, bl1, ls1, fs1;
  logic [3:0] x1, y1;
  logic [7:0] fc1;
  logic hs2, vs2, sb2, bl2, ls2, fs2;
  logic [4:0] x2, y2;
  logic [2:0] fc2;

  vga_timing_gen d0 (
    .vgaclk(vgaclk), .reset_b(reset_b), .pix_en(pix_en), .hsync(hs0), .vsync(vs0), .sync_b(sb0),
    .blank_b(bl0), .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

  vga_timing_gen #(
    .HACTIVE(10), .HFP(2), .HSYN(3), .HBP(1), .VACTIVE(5), .VFP(1), .VSYN(2), .VBP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE(0), .CW(4), .FCW(8)
  ) d1 (
    .vgaclk(vgaclk), .reset_b(reset_b), .pix_en(pix_en), .hsync(hs1), .vsync(vs1), .sync_b(sb1),
    .blank_b(bl1), .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1));

  vga_timing_gen #(
    .HACTIVE(5), .HFP(2), .HSYN(2), .HBP(3), .VACTIVE(4), .VFP(2), .VSYN(1), .VBP(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE(3), .CW(5), .FCW(3)
  ) d2 (
    .vgaclk(vgaclk), .reset_b(reset_b), .pix_en(pix_en), .hsync(hs2), .vsync(vs2), .sync_b(sb2),
    .blank_b(bl2), .x(x2), .y(y2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2));

  int total = 0, bad = 0, n = 0;
  bit chk_on = 1'b0;

  typedef struct {int hs, vs, bl, x, y, ls, fs, fc;} exp_t;

  // expected outputs after n enabled pixels since reset: position is n mod the raster,
  // delayed outputs reflect the raster position PIPE pixels earlier (idle before that)
  function automatic exp_t model(input int ha, hfp, hsy, hbp, va, vfp, vsy, vbp, hp, vp, pipe, fcw, cnt, en);
    exp_t e;
    int ht, vt, m, hc, vc;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    e.x = cnt % ht;
    e.y = (cnt / ht) % vt;
    e.fc = (cnt / (ht * vt)) % (1 << fcw);
    e.ls = (en != 0 && e.x == 0) ? 1 : 0;
    e.fs = (e.ls != 0 && e.y == 0) ? 1 : 0;
    m = cnt - pipe;
    if (m < 0) begin
      e.hs = 1 - hp;
      e.vs = 1 - vp;
      e.bl = 0;
    end else begin
      hc = m % ht;
      vc = (m / ht) % vt;
      e.hs = (hc >= ha + hfp && hc < ha + hfp + hsy) ? hp : 1 - hp;
      e.vs = (vc >= va + vfp && vc < va + vfp + vsy) ? vp : 1 - vp;
      e.bl = (hc < ha && vc < va) ? 1 : 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t n=%0d", nm, act, req, $time, n);
    end
  endtask

  task automatic cmp(input string nm, input logic hs, vs, sb, bl, ls, fs, input int x, y, fc, input exp_t e);
    chk({nm, ".hsync"}, int'(hs), e.hs);
    chk({nm, ".vsync"}, int'(vs), e.vs);
    chk({nm, ".sync_b"}, int'(sb), 0);
    chk({nm, ".blank_b"}, int'(bl), e.bl);
    chk({nm, ".line_start"}, int'(ls), e.ls);
    chk({nm, ".frame_start"}, int'(fs), e.fs);
    chk({nm, ".x"}, x, e.x);
    chk({nm, ".y"}, y, e.y);
    chk({nm, ".frame_cnt"}, fc, e.fc);
  endtask

  // enabled-pixel count since reset drives the model
  always @(posedge vgaclk or negedge reset_b)
    if (!reset_b) n <= 0;
    else if (pix_en) n <= n + 1;

  // every-cycle comparison of all three instances
  always @(negedge vgaclk) begin
    if (chk_on) begin
      cmp("d0", hs0, vs0, sb0, bl0, ls0, fs0, int'(x0), int'(y0), int'(fc0),
          model(640, 16, 96, 48, 480, 11, 2, 32, 0, 0, 2, 8, n, int'(pix_en)));
      cmp("d1", hs1, vs1, sb1, bl1, ls1, fs1, int'(x1), int'(y1), int'(fc1),
          model(10, 2, 3, 1, 5, 1, 2, 1, 1, 1, 0, 8, n, int'(pix_en)));
      cmp("d2", hs2, vs2, sb2, bl2, ls2, fs2, int'(x2), int'(y2), int'(fc2),
          model(5, 2, 2, 3, 4, 2, 1, 2, 1, 0, 3, 3, n, int'(pix_en)));
    end
  end

  // wall-clock measurements of the default instance: line period and hsync pulse width
  int cyc = 0, last_ls = -1, ls_gap = 0, run = 0, last_run = 0, first_low_x = -1;
  always @(negedge vgaclk) begin
    cyc++;
    if (ls0) begin
      if (last_ls >= 0) ls_gap = cyc - last_ls;
      last_ls = cyc;
    end
    if (!hs0) begin
      if (run == 0 && first_low_x < 0) first_low_x = int'(x0);
      run++;
    end else if (run > 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic step(input logic en);
    @(posedge vgaclk);
    #1 pix_en = en;
    @(negedge vgaclk);
  endtask

  initial begin
    int g;
    #1 reset_b = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) step(1'b0);
    chk("rst_x", int'(x0), 0);
    chk("rst_hsync", int'(hs0), 1);
    chk("rst_vsync", int'(vs0), 1);
    chk("rst_blank", int'(bl0), 0);
    chk("rst_hsync_pol1", int'(hs1), 0);
    @(posedge vgaclk);
    #1 reset_b = 1'b1;
    pix_en = 1'b1;
    @(negedge vgaclk);
    chk("first_frame_start", int'(fs0), 1);
    for (int i = 0; i < 2000; i++) begin
      step(1'b1);
      case (n)
        2:   chk("d2_blank_hold", int'(bl2), 0);
        3:   chk("d2_blank_rise", int'(bl2), 1);
        7:   chk("d2_blank_last", int'(bl2), 1);
        8:   chk("d2_blank_fall", int'(bl2), 0);
        9:   chk("d1_blank_last", int'(bl1), 1);
        10:  chk("d1_blank_fall", int'(bl1), 0);
        11:  chk("d1_hsync_idle", int'(hs1), 0);
        12:  chk("d1_hsync_on", int'(hs1), 1);
        14:  chk("d2_blank_porch", int'(bl2), 0);
        15:  chk("d2_blank_line1", int'(bl2), 1);
        641: chk("d0_blank_last", int'(bl0), 1);
        642: chk("d0_blank_fall", int'(bl0), 0);
        657: chk("d0_hsync_pre", int'(hs0), 1);
        658: chk("d0_hsync_on", int'(hs0), 0);
        753: chk("d0_hsync_end", int'(hs0), 0);
        754: chk("d0_hsync_off", int'(hs0), 1);
        default: ;
      endcase
    end
    chk("line_period_en", ls_gap, 800);
    chk("hsync_width_en", last_run, 96);
    chk("hsync_first_x", first_low_x, 658);
    for (int i = 0; i < 3400; i++) step(i % 2 == 0);
    chk("line_period_toggle", ls_gap, 1600);
    chk("hsync_width_toggle", last_run, 192);
    for (int i = 0; i < 1000 && int'(x0) != 300; i++) step(1'b1);
    chk("seek_x300", int'(x0), 300);
    @(posedge vgaclk);
    #3 reset_b = 1'b0;
    #1;
    chk("midrst_x", int'(x0), 0);
    chk("midrst_y", int'(y0), 0);
    chk("midrst_hsync", int'(hs0), 1);
    chk("midrst_vsync", int'(vs0), 1);
    chk("midrst_blank", int'(bl0), 0);
    chk("midrst_fcnt", int'(fc0), 0);
    pix_en = 1'b0;
    @(posedge vgaclk);
    #1 reset_b = 1'b1;
    pix_en = 1'b1;
    @(negedge vgaclk);
    chk("midrst_frame_start", int'(fs0), 1);
    chk("midrst_blank_hold0", int'(bl0), 0);
    step(1'b1);
    chk("midrst_blank_hold1", int'(bl0), 0);
    g = 0;
    while (n + int'(pix_en) < 36863 && g < 60000) begin
      step($urandom_range(0, 3) != 0);
      g++;
    end
    step(1'b0);
    chk("wrap_reached", n, 36863);
    chk("wrap_pre_x", int'(x1), 15);
    chk("wrap_pre_y", int'(y1), 8);
    chk("wrap_pre_fcnt", int'(fc1), 255);
    step(1'b1);
    step(1'b1);
    chk("wrap_x", int'(x1), 0);
    chk("wrap_y", int'(y1), 0);
    chk("wrap_frame_start", int'(fs1), 1);
    chk("wrap_fcnt", int'(fc1), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
